// File: rtl/uart_tx_param.sv
// Purpose : parametrised UART transmitter (configurable data bits, parity, stop bits) fed by a small transmit FIFO.
// Latency : write sampled at edge N drives the start bit from edge N+2; one idle-high clock separates queued frames.
// Backpr. : o_Tx_Ready low while the FIFO is full; writes while full are dropped and latch o_Overflow until reset.
//
// Ports:
//   i_Clock, i_Reset         clock, asynchronous active-high reset
//   i_Tx_DV, i_Tx_Byte       write strobe and character to queue
//   o_Tx_Ready, o_Fifo_Count FIFO not-full flag and occupancy
//   o_Overflow               sticky dropped-write flag
//   o_Tx_Active, o_Tx_Serial frame-in-progress flag and serial line (idles high)
//   o_Tx_Done                one-cycle pulse when the line returns to idle after a frame

// Purpose : generic synchronous FIFO with pointer-derived occupancy.
// Latency : written data visible at rd_dat the cycle after the write edge.
// Backpr. : wr_rdy low when full; a write while full is ignored even if a read fires in the same cycle.
module fifo_sync #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          wr_rdy,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_fire;
    logic          rd_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign wr_rdy  = (count != FULL);
    assign rd_vld  = (count != '0);
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_rdy && rd_vld;
    assign rd_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module uart_tx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           ODD_MODE  = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         baud_cnt;
    logic [3:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shift_dat;
    logic                  par_bit;
    logic                  serial_nxt;
    logic                  pop;
    logic                  baud_last;

    logic                  fifo_wr_rdy;
    logic                  fifo_rd_vld;
    logic [DATA_BITS-1:0]  fifo_rd_dat;

    fifo_sync #(
        .DW    (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_Clock),
        .rst    (i_Reset),
        .wr_vld (i_Tx_DV),
        .wr_dat (i_Tx_Byte),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (pop),
        .rd_dat (fifo_rd_dat),
        .count  (o_Fifo_Count)
    );

    assign o_Tx_Ready = fifo_wr_rdy;
    assign baud_last  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) o_Overflow <= 1'b0;
        else if (i_Tx_DV && !fifo_wr_rdy) o_Overflow <= 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        serial_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (fifo_rd_vld) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                serial_nxt = 1'b0;
                if (baud_last) state_nxt = DATA;
            end
            DATA: begin
                serial_nxt = shift_dat[0];
                if (baud_last && bit_cnt == DATA_LAST)
                    state_nxt = (PARITY != 0) ? PARITY_BIT : STOP;
            end
            PARITY_BIT: begin
                serial_nxt = par_bit;
                if (baud_last) state_nxt = STOP;
            end
            STOP: begin
                if (baud_last && bit_cnt == STOP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit and baud counters restart on every state change.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_dat <= '0;
            par_bit   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != IDLE) begin
                if (baud_last) begin
                    baud_cnt <= '0;
                    bit_cnt  <= bit_cnt + 1'b1;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
            if (pop) begin
                shift_dat <= fifo_rd_dat;
                // XOR of the data gives the even-parity bit; odd mode inverts it.
                par_bit   <= (^fifo_rd_dat) ^ ODD_MODE;
            end else if (state == DATA && baud_last) begin
                shift_dat <= shift_dat >> 1;
            end
        end
    end

    // Line and status are registered one stage behind the state, so the line
    // is glitch-free and Done lands on the first cycle the line shows idle.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Serial <= serial_nxt;
            o_Tx_Active <= (state != IDLE);
            o_Tx_Done   <= (state == IDLE) && o_Tx_Active;
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] dv;
    logic [7:0] byt [4];
    logic [3:0] ser, act, done, rdy, ovf;
    logic [2:0] cnt [4];

    int vec_cnt = 0;
    int err_cnt = 0;

    // 0: 8N1, 1: 8E2, 2: 8O1, 3: 5N1 -- all at 4 clocks per bit, FIFO depth 4
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(byt[0]),
        .o_Tx_Ready(rdy[0]), .o_Fifo_Count(cnt[0]), .o_Overflow(ovf[0]),
        .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8e2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(byt[1]),
        .o_Tx_Ready(rdy[1]), .o_Fifo_Count(cnt[1]), .o_Overflow(ovf[1]),
        .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(byt[2]),
        .o_Tx_Ready(rdy[2]), .o_Fifo_Count(cnt[2]), .o_Overflow(ovf[2]),
        .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_5n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(byt[3][4:0]),
        .o_Tx_Ready(rdy[3]), .o_Fifo_Count(cnt[3]), .o_Overflow(ovf[3]),
        .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(done[3]));

    // line: expected line level per bit period, bit 0 = start bit.
    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [15:0] line;
        int          len;
        string       name;
    } fvec_t;

    fvec_t fv [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int sel, input logic [7:0] d);
        dv[sel]  = 1'b1;
        byt[sel] = d;
        @(negedge clk);
        dv[sel]  = 1'b0;
    endtask

    task automatic wait_low(input int sel, input int maxc, output int k);
        k = 0;
        while (ser[sel] !== 1'b0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Entered on the first start-bit cycle; leaves on the cycle Done is expected.
    task automatic check_frame(input int sel, input string name, input logic [15:0] line, input int len);
        logic [3:0] s;
        logic       a_ok;
        logic       d_any;
        s = '0; a_ok = 1'b1; d_any = 1'b0;
        for (int c = 0; c < len; c++) begin
            s[c % 4] = ser[sel];
            a_ok     = a_ok & act[sel];
            d_any    = d_any | done[sel];
            @(negedge clk);
            if (c % 4 == 3) begin
                chk($sformatf("%s_bit%0d", name, c / 4),
                    {26'b0, a_ok, d_any, s}, {26'b0, 1'b1, 1'b0, {4{line[c / 4]}}});
                a_ok = 1'b1; d_any = 1'b0;
            end
        end
        chk($sformatf("%s_end", name), {29'b0, done[sel], act[sel], ser[sel]}, 32'h5);
    endtask

    // Frames queued back-to-back on instance 0; entered on the first start cycle of the first.
    task automatic check_chain(input string base, input int n, input logic [15:0] lines [4]);
        for (int f = 0; f < n; f++) begin
            check_frame(0, $sformatf("%s_f%0d", base, f), lines[f], 40);
            chk($sformatf("%s_cnt%0d", base, f), 32'(cnt[0]), (f < n - 1) ? 32'(n - 2 - f) : 32'd0);
            @(negedge clk);
            chk($sformatf("%s_gap%0d", base, f), 32'(ser[0]), (f < n - 1) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (ser[0] !== 1'b1 || act[0] !== 1'b0 || done[0] !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] q4 [4];
        int exp_cnt [5];
        logic [7:0] fifo_dat [5];

        fv[0]  = '{0, 8'hA3, 16'h0346, 40, "8n1_a3"};
        fv[1]  = '{0, 8'h55, 16'h02AA, 40, "8n1_55"};
        fv[2]  = '{1, 8'h07, 16'h0E0E, 48, "8e2_07"};
        fv[3]  = '{1, 8'hFF, 16'h0DFE, 48, "8e2_ff"};
        fv[4]  = '{1, 8'h00, 16'h0C00, 48, "8e2_00"};
        fv[5]  = '{2, 8'h07, 16'h040E, 44, "8o1_07"};
        fv[6]  = '{2, 8'h00, 16'h0600, 44, "8o1_00"};
        fv[7]  = '{2, 8'hFF, 16'h07FE, 44, "8o1_ff"};
        fv[8]  = '{3, 8'h1F, 16'h007E, 28, "5n1_1f"};
        fv[9]  = '{3, 8'h0A, 16'h0054, 28, "5n1_0a"};
        fv[10] = '{0, 8'h80, 16'h0300, 40, "8n1_80"};
        exp_cnt  = '{1, 2, 3, 4, 4};
        fifo_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        dv = '0;
        for (int i = 0; i < 4; i++) byt[i] = '0;

        // Reset values, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk("rst_serial", 32'(ser[0]), 32'd1);
        chk("rst_active", 32'(act[0]), 32'd0);
        chk("rst_done",   32'(done[0]), 32'd0);
        chk("rst_ovf",    32'(ovf[0]), 32'd0);
        chk("rst_count",  32'(cnt[0]), 32'd0);
        chk("rst_ready",  32'(rdy[0]), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frames across all formats.
        for (int i = 0; i < 11; i++) begin
            push(fv[i].sel, fv[i].data);
            wait_low(fv[i].sel, 20, k);
            chk({fv[i].name, "_lat"}, 32'(k), 32'd2);
            if (k < 20) check_frame(fv[i].sel, fv[i].name, fv[i].line, fv[i].len);
            @(negedge clk);
            chk({fv[i].name, "_done1"}, 32'(done[fv[i].sel]), 32'd0);
            repeat (3) @(negedge clk);
        end

        // FIFO fill while busy, overflow, back-to-back drain.
        push(0, 8'h00);
        wait_low(0, 20, k);
        chk("fifo_lat", 32'(k), 32'd2);
        chk("fifo_cnt0", 32'(cnt[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            dv[0] = 1'b1; byt[0] = fifo_dat[i];
            @(negedge clk);
            chk($sformatf("fifo_cnt_w%0d", i), 32'(cnt[0]), 32'(exp_cnt[i]));
            chk($sformatf("fifo_rdy_w%0d", i), 32'(rdy[0]), (i < 3) ? 32'd1 : 32'd0);
        end
        dv[0] = 1'b0;
        chk("fifo_ovf", 32'(ovf[0]), 32'd1);
        k = 0;
        while (done[0] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("fifo_dummy_done", 32'(done[0]), 32'd1);
        chk("fifo_cnt_pop1", 32'(cnt[0]), 32'd3);
        @(negedge clk);
        chk("fifo_gap0", 32'(ser[0]), 32'd0);
        q4 = '{16'h0222, 16'h0244, 16'h0266, 16'h0288};
        check_chain("fifo", 4, q4);
        check_quiet("fifo_quiet", 20);
        chk("fifo_ovf_sticky", 32'(ovf[0]), 32'd1);
        chk("fifo_rdy_back", 32'(rdy[0]), 32'd1);

        // Write on the same edge the FSM pops with two entries queued.
        push(0, 8'h00);
        wait_low(0, 20, k);
        dv[0] = 1'b1; byt[0] = 8'hA1;
        @(negedge clk);
        byt[0] = 8'hB2;
        @(negedge clk);
        dv[0] = 1'b0;
        chk("sim_cnt2", 32'(cnt[0]), 32'd2);
        repeat (37) @(negedge clk);
        dv[0] = 1'b1; byt[0] = 8'hC3;
        @(negedge clk);
        dv[0] = 1'b0;
        chk("sim_done", 32'(done[0]), 32'd1);
        chk("sim_cnt_same", 32'(cnt[0]), 32'd2);
        @(negedge clk);
        chk("sim_gap0", 32'(ser[0]), 32'd0);
        q4 = '{16'h0342, 16'h0364, 16'h0386, 16'h0000};
        check_chain("sim", 3, q4);

        // Reset in the middle of data bit 3 with two entries queued.
        push(0, 8'h00);
        wait_low(0, 20, k);
        push(0, 8'hA1);
        push(0, 8'hB2);
        chk("rmid_cnt", 32'(cnt[0]), 32'd2);
        repeat (16) @(negedge clk);
        chk("rmid_pre_line", {30'b0, act[0], ser[0]}, 32'h2);
        chk("rmid_pre_ovf", 32'(ovf[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rmid_line", 32'(ser[0]), 32'd1);
        chk("rmid_cnt0", 32'(cnt[0]), 32'd0);
        chk("rmid_ovf0", 32'(ovf[0]), 32'd0);
        chk("rmid_act0", 32'(act[0]), 32'd0);
        chk("rmid_done0", 32'(done[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_quiet("rmid_quiet", 60);
        push(0, 8'h55);
        wait_low(0, 20, k);
        chk("rmid_new_lat", 32'(k), 32'd2);
        if (k < 20) check_frame(0, "rmid_new", 16'h02AA, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
